// File: rtl/axi4_slave_mem_responder.sv
// AXI4 slave endpoint backed by a word-addressed memory; one write and one read burst in flight concurrently.
// Latency: AW->wready 1 cycle, wlast->bvalid 1 cycle, AR->first rvalid 1 cycle, R handshake->next beat 1 cycle.
// Backpressure: bvalid/rvalid and their payloads hold until bready/rready; awready/arready are low while a burst is active.
// Optional feature macro: AXI4_SLV_ERR_INJECT_EN (bursts starting at or above ERR_BASE return SLVERR).
module axi4_slave_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] ERR_BASE = ADDR_WIDTH'(32'h0000_F000)
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  // Upper address bits are dropped, so the memory aliases modulo MEM_DEPTH.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[LSB +: IDX_W];
  endfunction

  // Address of the following beat; WRAP with an illegal length degrades to INCR.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [7:0]            len,
                                                       input logic [2:0]            size,
                                                       input logic [1:0]            burst);
    logic [ADDR_WIDTH-1:0] sum;
    logic [ADDR_WIDTH-1:0] wmask;
    logic [ADDR_WIDTH-1:0] res;
    sum   = a + (ADDR_WIDTH'(1) << size);
    wmask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    res   = sum;
    if (burst == BURST_FIXED) begin
      res = a;
    end else if (burst == BURST_WRAP &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      res = (a & ~wmask) | (sum & wmask);
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic aw_in_err;
  logic ar_in_err;
`ifdef AXI4_SLV_ERR_INJECT_EN
  assign aw_in_err = (awaddr >= ERR_BASE);
  assign ar_in_err = (araddr >= ERR_BASE);
`else
  // Error region disabled: the compare is masked off so ERR_BASE has no effect.
  assign aw_in_err = 1'b0 & (awaddr >= ERR_BASE);
  assign ar_in_err = 1'b0 & (araddr >= ERR_BASE);
`endif

  // ---------------- write channel ----------------
  w_state_t              w_state, w_nxt;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic                  aw_rsvd;
  logic                  aw_blk;
  logic [8:0]            w_cnt;
  logic                  aw_hs, w_hs, b_hs, mem_we;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign b_hs   = bvalid && bready;
  // Beats past awlen+1 are swallowed; blocked bursts never touch memory.
  assign mem_we = w_hs && (w_cnt <= {1'b0, aw_len}) && !aw_blk;

  // Write FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_nxt;
  end

  // Write FSM next-state logic.
  always_comb begin
    w_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs)          w_nxt = W_DATA;
      W_DATA:  if (w_hs && wlast)  w_nxt = W_RESP;
      W_RESP:  if (b_hs)           w_nxt = W_IDLE;
      default:                     w_nxt = W_IDLE;
    endcase
  end

  // Write burst context, beat counting and registered AW/W/B outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= RESP_OKAY;
      aw_id    <= '0;
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_burst <= '0;
      aw_rsvd  <= 1'b0;
      aw_blk   <= 1'b0;
      w_cnt    <= '0;
    end else begin
      awready <= (w_nxt == W_IDLE);
      wready  <= (w_nxt == W_DATA);
      bvalid  <= (w_nxt == W_RESP);
      if (aw_hs) begin
        aw_id    <= awid;
        aw_addr  <= awaddr;
        aw_len   <= awlen;
        aw_size  <= awsize;
        aw_burst <= awburst;
        aw_rsvd  <= (awburst == BURST_RSVD);
        aw_blk   <= aw_in_err;
        w_cnt    <= '0;
      end
      if (w_hs) begin
        aw_addr <= next_addr(aw_addr, aw_len, aw_size, aw_burst);
        if (w_cnt != 9'h1FF) w_cnt <= w_cnt + 9'd1;
        if (wlast) begin
          bid   <= aw_id;
          // The wlast beat is number w_cnt+1, so a correct burst has w_cnt == awlen here.
          bresp <= (w_cnt == {1'b0, aw_len} && !aw_rsvd && !aw_blk) ? RESP_OKAY : RESP_SLVERR;
        end
      end
    end
  end

  // Byte-strobed memory write; contents survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[word_idx(aw_addr)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t              r_state, r_nxt;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic                  ar_blk;
  logic [7:0]            r_cnt;
  logic                  ar_hs, r_hs;

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_nxt;
  end

  // Read FSM next-state logic.
  always_comb begin
    r_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)          r_nxt = R_DATA;
      R_DATA:  if (r_hs && rlast)  r_nxt = R_IDLE;
      default:                     r_nxt = R_IDLE;
    endcase
  end

  // Read beat loading: ar_addr always points at the beat to load next, so the
  // presented beat is only replaced on a handshake and stays stable during stalls.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rid      <= '0;
      rresp    <= RESP_OKAY;
      rdata    <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
      ar_blk   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      arready <= (r_nxt == R_IDLE);
      rvalid  <= (r_nxt == R_DATA);
      if (ar_hs) begin
        rid      <= arid;
        rresp    <= (arburst == BURST_RSVD || ar_in_err) ? RESP_SLVERR : RESP_OKAY;
        rdata    <= ar_in_err ? '0 : mem[word_idx(araddr)];
        rlast    <= (arlen == 8'd0);
        ar_addr  <= next_addr(araddr, arlen, arsize, arburst);
        ar_len   <= arlen;
        ar_size  <= arsize;
        ar_burst <= arburst;
        ar_blk   <= ar_in_err;
        r_cnt    <= '0;
      end else if (r_hs) begin
        if (rlast) begin
          rlast <= 1'b0;
        end else begin
          rdata   <= ar_blk ? '0 : mem[word_idx(ar_addr)];
          ar_addr <= next_addr(ar_addr, ar_len, ar_size, ar_burst);
          r_cnt   <= r_cnt + 8'd1;
          rlast   <= ((r_cnt + 8'd1) == ar_len);
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem_responder.sv
// Directed bench for axi4_slave_mem_responder: write/read bursts with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
// Every comparison goes through check(); the summary line reports its counters.
module tb_axi4_slave_mem_responder;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  axi4_slave_mem_responder dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All channel tasks start and end 1 time unit after a rising edge.
  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    @(negedge aclk);
    while (!awready && n < 100) begin n++; @(negedge aclk); end
    if (!awready) check("aw_timeout", awready, 1);
    @(posedge aclk); #1 awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    @(negedge aclk);
    while (!wready && n < 100) begin n++; @(negedge aclk); end
    if (!wready) check("w_timeout", wready, 1);
    @(posedge aclk); #1 wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic get_b(output logic [3:0] id, output logic [1:0] resp);
    int n = 0;
    bready = 1'b1;
    @(negedge aclk);
    while (!bvalid && n < 100) begin n++; @(negedge aclk); end
    if (!bvalid) check("b_timeout", bvalid, 1);
    id = bid; resp = bresp;
    @(posedge aclk); #1 bready = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    @(negedge aclk);
    while (!arready && n < 100) begin n++; @(negedge aclk); end
    if (!arready) check("ar_timeout", arready, 1);
    @(posedge aclk); #1 arvalid = 1'b0;
  endtask

  task automatic get_r(output logic [31:0] data, output logic [1:0] resp,
                       output logic last, output logic [3:0] id);
    int n = 0;
    rready = 1'b1;
    @(negedge aclk);
    while (!rvalid && n < 100) begin n++; @(negedge aclk); end
    if (!rvalid) check("r_timeout", rvalid, 1);
    data = rdata; resp = rresp; last = rlast; id = rid;
    @(posedge aclk); #1 rready = 1'b0;
  endtask

  // Single-beat full-word write that must complete OKAY.
  task automatic write_word(input string tag, input logic [31:0] addr, input logic [31:0] data);
    logic [3:0] id;
    logic [1:0] resp;
    do_aw(4'h1, addr, 8'd0, 3'd2, INCR);
    do_w(data, 4'hF, 1'b1);
    get_b(id, resp);
    check(tag, resp, OKAY);
  endtask

  // Single-beat read checked against an expected word.
  task automatic read_word(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
    do_ar(4'h2, addr, 8'd0, 3'd2, INCR);
    get_r(d, resp, last, id);
    check(tag, d, exp);
  endtask

  initial begin : main
    logic [31:0] d;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
    logic [31:0] exp4 [4];

    // Reset state.
    #2;
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid",  bvalid,  0);
    check("rst_rvalid",  rvalid,  0);
    check("rst_rdata",   rdata,   0);
    #10 aresetn = 1'b1;
    #2 check("awready_before_edge", awready, 0);
    @(posedge aclk); #1;
    check("awready_after_rst", awready, 1);
    check("arready_after_rst", arready, 1);

    // 1: single write then read, with latency checks.
    do_aw(4'h3, 32'h100, 8'd0, 3'd2, INCR);
    check("t1_wready_lat", wready, 1);
    check("t1_awready_low", awready, 0);
    do_w(32'hDEADBEEF, 4'hF, 1'b1);
    get_b(id, resp);
    check("t1_bid", id, 4'h3);
    check("t1_bresp", resp, OKAY);
    check("t1_awready_back", awready, 1);
    do_ar(4'h5, 32'h100, 8'd0, 3'd2, INCR);
    check("t1_rvalid_lat", rvalid, 1);
    check("t1_arready_low", arready, 0);
    get_r(d, resp, last, id);
    check("t1_rdata", d, 32'hDEADBEEF);
    check("t1_rlast", last, 1);
    check("t1_rresp", resp, OKAY);
    check("t1_rid", id, 4'h5);
    check("t1_rvalid_drop", rvalid, 0);
    read_word("alias_rdata", 32'h1100, 32'hDEADBEEF);

    // 2: INCR write with a half-word strobe on the third beat.
    write_word("t2_pre_bresp", 32'h208, 32'hAAAA5555);
    do_aw(4'h6, 32'h200, 8'd3, 3'd2, INCR);
    do_w(32'h1, 4'hF, 1'b0);
    do_w(32'h2, 4'hF, 1'b0);
    do_w(32'h3, 4'h3, 1'b0);
    do_w(32'h4, 4'hF, 1'b1);
    get_b(id, resp);
    check("t2_bresp", resp, OKAY);
    exp4 = '{32'h1, 32'h2, 32'hAAAA0003, 32'h4};
    do_ar(4'h7, 32'h200, 8'd3, 3'd2, INCR);
    for (int i = 0; i < 4; i++) begin
      get_r(d, resp, last, id);
      check($sformatf("t2_rdata%0d", i), d, exp4[i]);
      check($sformatf("t2_rlast%0d", i), last, (i == 3));
    end

    // 3: WRAP read from 0x38 wraps inside 0x30..0x3F.
    do_aw(4'h1, 32'h30, 8'd3, 3'd2, INCR);
    do_w(32'hA, 4'hF, 1'b0);
    do_w(32'hB, 4'hF, 1'b0);
    do_w(32'hC, 4'hF, 1'b0);
    do_w(32'hD, 4'hF, 1'b1);
    get_b(id, resp);
    check("t3_bresp", resp, OKAY);
    exp4 = '{32'hC, 32'hD, 32'hA, 32'hB};
    do_ar(4'h8, 32'h38, 8'd3, 3'd2, WRAP);
    for (int i = 0; i < 4; i++) begin
      get_r(d, resp, last, id);
      check($sformatf("t3_wrap%0d", i), d, exp4[i]);
    end

    // 4: stall mid-burst while the presented word is overwritten.
    do_ar(4'h9, 32'h30, 8'd3, 3'd2, INCR);
    get_r(d, resp, last, id);
    check("t4_beat0", d, 32'hA);
    @(negedge aclk);
    check("t4_stall_start", rdata, 32'hB);
    @(posedge aclk); #1;
    write_word("t4_wr_bresp", 32'h34, 32'h12345678);
    check("t4_stall_mid", rdata, 32'hB);
    repeat (5) @(posedge aclk);
    #1;
    check("t4_stall_end", rdata, 32'hB);
    check("t4_stall_rvalid", rvalid, 1);
    check("t4_stall_rlast", rlast, 0);
    get_r(d, resp, last, id);
    check("t4_beat1", d, 32'hB);
    get_r(d, resp, last, id);
    check("t4_beat2", d, 32'hC);
    get_r(d, resp, last, id);
    check("t4_beat3", d, 32'hD);
    read_word("t4_new_word", 32'h34, 32'h12345678);

    // 5: early wlast, then a normal write must still be accepted.
    do_aw(4'hA, 32'h400, 8'd3, 3'd2, INCR);
    do_w(32'h55, 4'hF, 1'b0);
    do_w(32'h66, 4'hF, 1'b1);
    get_b(id, resp);
    check("t5_early_bresp", resp, SLVERR);
    check("t5_early_bid", id, 4'hA);
    check("t5_awready", awready, 1);
    write_word("t5_next_bresp", 32'h404, 32'h77);

    // Late wlast: the extra beat is not written.
    do_aw(4'hB, 32'h500, 8'd0, 3'd2, INCR);
    do_w(32'h11111111, 4'hF, 1'b0);
    do_w(32'h22222222, 4'hF, 1'b1);
    get_b(id, resp);
    check("late_bresp", resp, SLVERR);
    read_word("late_rdata", 32'h500, 32'h11111111);

    // FIXED burst keeps hitting one word.
    do_aw(4'hC, 32'h600, 8'd1, 3'd2, FIXED);
    do_w(32'h1, 4'hF, 1'b0);
    do_w(32'h2, 4'hF, 1'b1);
    get_b(id, resp);
    check("fixed_bresp", resp, OKAY);
    do_ar(4'hC, 32'h600, 8'd1, 3'd2, FIXED);
    get_r(d, resp, last, id);
    check("fixed_r0", d, 32'h2);
    get_r(d, resp, last, id);
    check("fixed_r1", d, 32'h2);
    check("fixed_rlast", last, 1);

    // 6: reset during beat 2 of an 8-beat read.
    do_ar(4'hD, 32'h200, 8'd7, 3'd2, INCR);
    get_r(d, resp, last, id);
    get_r(d, resp, last, id);
    #1 check("t6_rvalid_pre", rvalid, 1);
    #1 aresetn = 1'b0;
    #1;
    check("t6_rvalid_async", rvalid, 0);
    check("t6_arready_rst", arready, 0);
    @(posedge aclk); #3 aresetn = 1'b1;
    #1 check("t6_arready_pre_edge", arready, 0);
    @(posedge aclk); #1;
    check("t6_arready_post", arready, 1);
    read_word("t6_after_rst", 32'h100, 32'hDEADBEEF);

`ifdef AXI4_SLV_ERR_INJECT_EN
    // Error region: reads return zero with SLVERR, writes are dropped.
    write_word("ei_pre_bresp", 32'h0, 32'hCAFEF00D);
    do_ar(4'hE, 32'hF000, 8'd1, 3'd2, INCR);
    get_r(d, resp, last, id);
    check("ei_rresp0", resp, SLVERR);
    check("ei_rdata0", d, 32'h0);
    get_r(d, resp, last, id);
    check("ei_rresp1", resp, SLVERR);
    do_aw(4'hE, 32'hF000, 8'd0, 3'd2, INCR);
    do_w(32'h99999999, 4'hF, 1'b1);
    get_b(id, resp);
    check("ei_bresp", resp, SLVERR);
    read_word("ei_no_write", 32'h0, 32'hCAFEF00D);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
